// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: range-checks the immediate, packs the instruction
// and presents it on a one-deep output stage with a running byte address.
//
// state | meaning
// EMPTY | no word held, out_valid low
// FULL  | encoded word held on out_instr/out_addr, waiting for out_ready
module instr_encoder #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            fmt,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [31:0]           imm,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  err_pulse,
    output logic                  imm_err,
    output logic [15:0]           word_count
);

    localparam logic [ADDR_WIDTH-1:0] BASE = BASE_ADDR[ADDR_WIDTH-1:0];

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        drain;
    logic        legal;
    logic [31:0] packed_word;

    always_comb begin
        legal       = 1'b0;
        packed_word = '0;
        case (fmt)
            3'd0: begin
                packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
                legal       = 1'b1;
            end
            3'd1: begin
                packed_word = {imm[11:0], rs1, funct3, rd, opcode};
                legal       = (&imm[31:11]) || !(|imm[31:11]);
            end
            3'd2: begin
                packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal       = (&imm[31:11]) || !(|imm[31:11]);
            end
            3'd3: begin
                packed_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal       = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            end
            3'd4: begin
                packed_word = {imm[31:12], rd, opcode};
                legal       = !(|imm[11:0]);
            end
            3'd5: begin
                packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal       = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            end
            default: begin
                packed_word = '0;
                legal       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A legal accept wins over a same-cycle drain so the stage refills with no bubble.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else if (accept && legal) begin
            state_nxt = FULL;
        end else if (drain) begin
            state_nxt = EMPTY;
        end
    end

    always_comb begin
        out_valid = (state == FULL);
        in_ready  = !flush && ((state == EMPTY) || out_ready);
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_instr  <= '0;
            out_addr   <= BASE;
            err_pulse  <= 1'b0;
            imm_err    <= 1'b0;
            word_count <= '0;
        end else begin
            err_pulse <= accept && !legal;
            if (accept && !legal) begin
                imm_err <= 1'b1;
            end
            if (accept && legal) begin
                out_instr <= packed_word;
            end
            // Flush discards any drain in the same cycle.
            if (flush) begin
                out_addr   <= BASE;
                word_count <= '0;
            end else if (drain) begin
                out_addr <= out_addr + ADDR_WIDTH'(4);
                if (word_count != 16'hFFFF) begin
                    word_count <= word_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: default instance plus a 4-bit-address
// instance sharing the same stimulus for the wrap scenario.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        flush;
    logic        out_ready;

    logic        in_ready,  in_ready4;
    logic        out_valid, out_valid4;
    logic [31:0] out_instr, out_instr4;
    logic [7:0]  out_addr;
    logic [3:0]  out_addr4;
    logic        err_pulse, err_pulse4;
    logic        imm_err,   imm_err4;
    logic [15:0] word_count, word_count4;

    int n_cmp = 0;
    int n_bad = 0;

    instr_encoder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .err_pulse(err_pulse), .imm_err(imm_err),
        .word_count(word_count)
    );

    instr_encoder #(.ADDR_WIDTH(4), .BASE_ADDR(0)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4),
        .out_addr(out_addr4), .err_pulse(err_pulse4), .imm_err(imm_err4),
        .word_count(word_count4)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  f;
        logic [6:0]  op;
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] im;
        logic        ok;
        logic [31:0] exp;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", out_instr); end
        n_cmp++; if (out_addr !== 8'h00) begin n_bad++; $display("FAIL rst_addr: got %h want 00", out_addr); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL rst_err_pulse: got %b want 0", err_pulse); end
        n_cmp++; if (imm_err !== 1'b0) begin n_bad++; $display("FAIL rst_imm_err: got %b want 0", imm_err); end
        n_cmp++; if (word_count !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", word_count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_r_type();
        out_ready = 1'b0;
        set_fields(3'd0, 7'h33, 5'd5, 5'd10, 5'd15, 3'd0, 7'd0, 32'h0);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL r_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_instr !== 32'h00F502B3) begin n_bad++; $display("FAIL r_instr: got %h want 00f502b3", out_instr); end
        n_cmp++; if (out_addr !== 8'h00) begin n_bad++; $display("FAIL r_addr: got %h want 00", out_addr); end
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL r_drain_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_addr !== 8'h04) begin n_bad++; $display("FAIL r_drain_addr: got %h want 04", out_addr); end
        n_cmp++; if (word_count !== 16'd1) begin n_bad++; $display("FAIL r_drain_count: got %0d want 1", word_count); end
    endtask

    task automatic test_i_s();
        do_flush();
        n_cmp++; if (out_addr !== 8'h00) begin n_bad++; $display("FAIL is_flush_addr: got %h want 00", out_addr); end
        out_ready = 1'b1;
        set_fields(3'd1, 7'h13, 5'd5, 5'd10, 5'd0, 3'd0, 7'd0, 32'd20);
        step();
        n_cmp++; if (out_instr !== 32'h01450293) begin n_bad++; $display("FAIL addi_instr: got %h want 01450293", out_instr); end
        n_cmp++; if (out_addr !== 8'h00) begin n_bad++; $display("FAIL addi_addr: got %h want 00", out_addr); end
        set_fields(3'd2, 7'h23, 5'd0, 5'd10, 5'd15, 3'd2, 7'd0, 32'd8);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL sw_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_instr !== 32'h00F52423) begin n_bad++; $display("FAIL sw_instr: got %h want 00f52423", out_instr); end
        n_cmp++; if (out_addr !== 8'h04) begin n_bad++; $display("FAIL sw_addr: got %h want 04", out_addr); end
        step();
        n_cmp++; if (word_count !== 16'd2) begin n_bad++; $display("FAIL is_count: got %0d want 2", word_count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL is_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_b_illegal();
        do_flush();
        out_ready = 1'b1;
        set_fields(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_instr !== 32'hFE000EE3) begin n_bad++; $display("FAIL beq_instr: got %h want fe000ee3", out_instr); end
        step();
        n_cmp++; if (out_addr !== 8'h04) begin n_bad++; $display("FAIL beq_addr_after: got %h want 04", out_addr); end
        set_fields(3'd1, 7'h13, 5'd5, 5'd10, 5'd0, 3'd0, 7'd0, 32'd2048);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ill_valid: got %b want 0", out_valid); end
        n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL ill_pulse: got %b want 1", err_pulse); end
        n_cmp++; if (imm_err !== 1'b1) begin n_bad++; $display("FAIL ill_sticky: got %b want 1", imm_err); end
        n_cmp++; if (out_addr !== 8'h04) begin n_bad++; $display("FAIL ill_addr: got %h want 04", out_addr); end
        step();
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL ill_pulse_end: got %b want 0", err_pulse); end
        n_cmp++; if (imm_err !== 1'b1) begin n_bad++; $display("FAIL ill_sticky_hold: got %b want 1", imm_err); end
        set_fields(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
        step();
        in_valid = 1'b0;
        n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL fmt7_pulse: got %b want 1", err_pulse); end
        n_cmp++; if (word_count !== 16'd1) begin n_bad++; $display("FAIL fmt7_count: got %0d want 1", word_count); end
        // illegal word arriving while a held word drains
        out_ready = 1'b0;
        set_fields(3'd1, 7'h13, 5'd5, 5'd10, 5'd0, 3'd0, 7'd0, 32'd20);
        step();
        set_fields(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ill_drain_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_addr !== 8'h08) begin n_bad++; $display("FAIL ill_drain_addr: got %h want 08", out_addr); end
        n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL ill_drain_pulse: got %b want 1", err_pulse); end
        n_cmp++; if (word_count !== 16'd2) begin n_bad++; $display("FAIL ill_drain_count: got %0d want 2", word_count); end
    endtask

    task automatic test_formats();
        vec_t tbl [12];
        tbl[0]  = '{3'd4, 7'h37, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h1234_5000, 1'b1, 32'h123450B7};
        tbl[1]  = '{3'd5, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0008, 1'b1, 32'h008000EF};
        tbl[2]  = '{3'd1, 7'h13, 5'd5,  5'd10, 5'd0,  3'd0, 7'h00, 32'hFFFF_F800, 1'b1, 32'h80050293};
        tbl[3]  = '{3'd1, 7'h13, 5'd5,  5'd10, 5'd0,  3'd0, 7'h00, 32'h0000_07FF, 1'b1, 32'h7FF50293};
        tbl[4]  = '{3'd1, 7'h13, 5'd5,  5'd10, 5'd0,  3'd0, 7'h00, 32'hFFFF_F7FF, 1'b0, 32'h0};
        tbl[5]  = '{3'd2, 7'h23, 5'd0,  5'd10, 5'd15, 3'd2, 7'h00, 32'hFFFF_FFFF, 1'b1, 32'hFEF52FA3};
        tbl[6]  = '{3'd2, 7'h23, 5'd0,  5'd10, 5'd15, 3'd2, 7'h00, 32'h0000_0800, 1'b0, 32'h0};
        tbl[7]  = '{3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0FFE, 1'b1, 32'h7E000FE3};
        tbl[8]  = '{3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0003, 1'b0, 32'h0};
        tbl[9]  = '{3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_1000, 1'b0, 32'h0};
        tbl[10] = '{3'd5, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h0000_0005, 1'b0, 32'h0};
        tbl[11] = '{3'd0, 7'h33, 5'd5,  5'd10, 5'd15, 3'd0, 7'h20, 32'hDEAD_BEEF, 1'b1, 32'h40F502B3};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_fields(tbl[i].f, tbl[i].op, tbl[i].d, tbl[i].s1, tbl[i].s2, tbl[i].f3, tbl[i].f7, tbl[i].im);
            step();
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== tbl[i].ok) begin n_bad++; $display("FAIL fmt_valid[%0d]: got %b want %b", i, out_valid, tbl[i].ok); end
            n_cmp++; if (err_pulse !== !tbl[i].ok) begin n_bad++; $display("FAIL fmt_pulse[%0d]: got %b want %b", i, err_pulse, !tbl[i].ok); end
            if (tbl[i].ok) begin
                n_cmp++; if (out_instr !== tbl[i].exp) begin n_bad++; $display("FAIL fmt_instr[%0d]: got %h want %h", i, out_instr, tbl[i].exp); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        do_flush();
        out_ready = 1'b0;
        set_fields(3'd0, 7'h33, 5'd5, 5'd10, 5'd15, 3'd0, 7'd0, 32'h0);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        set_fields(3'd1, 7'h13, 5'd5, 5'd10, 5'd0, 3'd0, 7'd0, 32'd20);
        step();
        step();
        n_cmp++; if (out_instr !== 32'h00F502B3) begin n_bad++; $display("FAIL bp_hold_instr: got %h want 00f502b3", out_instr); end
        n_cmp++; if (out_addr !== 8'h00) begin n_bad++; $display("FAIL bp_hold_addr: got %h want 00", out_addr); end
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_pass_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_nobubble: got %b want 1", out_valid); end
        n_cmp++; if (out_instr !== 32'h01450293) begin n_bad++; $display("FAIL bp_second_instr: got %h want 01450293", out_instr); end
        n_cmp++; if (out_addr !== 8'h04) begin n_bad++; $display("FAIL bp_second_addr: got %h want 04", out_addr); end
        step();
        n_cmp++; if (word_count !== 16'd2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", word_count); end
    endtask

    task automatic test_wrap_flush();
        logic [3:0]  exp_a;
        logic [31:0] exp_w;
        do_flush();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_fields(3'd1, 7'h13, 5'd5, 5'd10, 5'd0, 3'd0, 7'd0, 32'(i));
            step();
            exp_a = 4'(i * 4);
            exp_w = 32'h00050293 | (32'(i) << 20);
            n_cmp++; if (out_addr4 !== exp_a) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, out_addr4, exp_a); end
            n_cmp++; if (out_instr4 !== exp_w) begin n_bad++; $display("FAIL wrap_instr[%0d]: got %h want %h", i, out_instr4, exp_w); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (out_addr !== 8'h10) begin n_bad++; $display("FAIL wide_addr: got %h want 10", out_addr); end
        n_cmp++; if (word_count4 !== 16'd4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", word_count4); end
        step();
        n_cmp++; if (out_valid4 !== 1'b1) begin n_bad++; $display("FAIL wrap_held: got %b want 1", out_valid4); end
        flush = 1'b1;
        #1;
        n_cmp++; if (in_ready4 !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b want 0", in_ready4); end
        step();
        flush = 1'b0;
        n_cmp++; if (out_valid4 !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", out_valid4); end
        n_cmp++; if (word_count4 !== 16'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", word_count4); end
        n_cmp++; if (imm_err4 !== 1'b1) begin n_bad++; $display("FAIL flush_imm_err: got %b want 1", imm_err4); end
        n_cmp++; if (err_pulse4 !== 1'b0) begin n_bad++; $display("FAIL flush_pulse: got %b want 0", err_pulse4); end
        set_fields(3'd1, 7'h13, 5'd5, 5'd10, 5'd0, 3'd0, 7'd0, 32'd9);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_addr4 !== 4'h0) begin n_bad++; $display("FAIL post_flush_addr: got %h want 0", out_addr4); end
        n_cmp++; if (out_valid4 !== 1'b1) begin n_bad++; $display("FAIL post_flush_valid: got %b want 1", out_valid4); end
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (word_count !== 16'd0) begin n_bad++; $display("FAIL flush_drain_count: got %0d want 0", word_count); end
        n_cmp++; if (out_addr !== 8'h00) begin n_bad++; $display("FAIL flush_drain_addr: got %h want 00", out_addr); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_fields(3'd1, 7'h13, 5'd5, 5'd10, 5'd0, 3'd0, 7'd0, 32'd20);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_full: got %b want 1", out_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL mid_rst_instr: got %h want 0", out_instr); end
        n_cmp++; if (imm_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_imm_err: got %b want 0", imm_err); end
        n_cmp++; if (word_count !== 16'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", word_count); end
        set_fields(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        step();
        in_valid = 1'b0;
        n_cmp++; if (out_instr !== 32'h008000EF) begin n_bad++; $display("FAIL mid_jal_instr: got %h want 008000ef", out_instr); end
        n_cmp++; if (out_addr !== 8'h00) begin n_bad++; $display("FAIL mid_jal_addr: got %h want 00", out_addr); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        test_reset();
        test_r_type();
        test_i_s();
        test_b_illegal();
        test_formats();
        test_backpressure();
        test_wrap_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Field-to-word RV32I instruction encoder, the inverse of the decode block. It accepts decoded fields (format, opcode, registers, functs, immediate) over a valid/ready handshake. It range-checks the immediate, packs the 32-bit instruction word and streams it out with a sequential word address. Used by the bench/boot path to fill instruction memory and to cross-check decode round-trips.

Parameters:
ADDR_WIDTH, 8, width of out_addr (byte address; wraps modulo 2^ADDR_WIDTH)
BASE_ADDR, 0, out_addr value after reset/flush; must be a multiple of 4

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  field set presented
in_ready  out  1  encoder can accept this cycle
fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J; 6,7 illegal
opcode  in  7  opcode field
rd  in  5  destination register
rs1  in  5  source register 1
rs2  in  5  source register 2
funct3  in  3  funct3 field
funct7  in  7  funct7 field (R only)
imm  in  32  immediate as a signed/unsigned byte value (unshifted)
flush  in  1  restart addressing at BASE_ADDR, drop held word
out_valid  out  1  out_instr/out_addr valid
out_ready  in  1  consumer accepts
out_instr  out  32  encoded instruction
out_addr  out  ADDR_WIDTH  byte address of out_instr
err_pulse  out  1  one-cycle pulse: accepted field set rejected
imm_err  out  1  sticky error flag, cleared only by rst
word_count  out  16  words emitted since rst/flush (saturates at 0xFFFF)

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_pulse=0, imm_err=0, word_count=0; any held word is discarded. Reset takes priority over flush and over all handshakes.
- Two states: EMPTY (out_valid=0) and FULL (out_valid=1). in_ready = !out_valid || out_ready (pass-through: accept in the same cycle the held word drains).
- Accept = in_valid && in_ready. Legal accept: out_instr is loaded and out_valid=1 on the next cycle (latency 1). The state is FULL unless the word was illegal.
- Drain = out_valid && out_ready: out_addr += 4 (mod 2^ADDR_WIDTH) and word_count += 1 (saturating). out_valid goes low unless a legal accept happens in the same cycle.
- out_instr and out_addr are stable while out_valid && !out_ready.
- Packing: R = funct7|rs2|rs1|funct3|rd|opcode. I = imm[11:0]|rs1|funct3|rd|opcode. S = imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode. B = imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode. U = imm[31:12]|rd|opcode. J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode. Unused fields are ignored.
- Legality checks:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: always legal.
  - fmt 6/7: illegal.
- Illegal accept: the word is dropped. err_pulse=1 for one cycle and imm_err is set. out_valid, out_addr and word_count are unaffected by the dropped word; any drain of the previously held word in the same cycle still applies.
- flush (rst=0): next cycle out_valid=0, out_addr=BASE_ADDR, word_count=0; imm_err is kept. in_ready=0 during the flush cycle, so no accept occurs. A drain coinciding with flush is ignored (no increment).

Test Plan:
- R: fmt=0, opcode=0x33, rd=5, rs1=10, rs2=15, funct3=0, funct7=0 -> next cycle out_valid=1, out_instr=0x00F502B3, out_addr=0x00.
- I then S, out_ready=1: ADDI x5,x10,20 -> 0x01450293 @0x00; SW x15,8(x10) (fmt=2, opcode=0x23, funct3=2, imm=8) -> 0x00F52423 @0x04; word_count=2.
- B, negative immediate: BEQ x0,x0,imm=-4 -> 0xFE000EE3. Then an illegal case: ADDI imm=2048 -> no out_valid, err_pulse for one cycle, imm_err=1, out_addr unchanged; also fmt=7 -> err_pulse.
- Backpressure: two words sent with out_ready=0 -> in_ready=0 after the first, out_instr/out_addr held. Raising out_ready drains the first and accepts the second in the same cycle (no bubble).
- Wrap/flush, ADDR_WIDTH=4: five legal words -> addresses 0x0,0x4,0x8,0xC,0x0. flush while FULL -> held word gone, next word at 0x0, word_count restarts, imm_err retained.
- Reset mid-operation: rst while FULL with out_ready=0 -> next cycle all outputs at reset values; a subsequent word encodes at BASE_ADDR.
